// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared definitions for the traffic phase scheduler.
//   lamp_t  : lamp drive encoding (00 green, 01 yellow, 10 red)
//   phase_t : scheduler state codes 0..6, also exported on o_phase
//   lamp_a / lamp_b : Moore decode from phase to the road A / road B lamp
package traffic_phase_scheduler_pkg;

  typedef enum logic [1:0] {
    LAMP_GREEN  = 2'b00,
    LAMP_YELLOW = 2'b01,
    LAMP_RED    = 2'b10
  } lamp_t;

  typedef enum logic [2:0] {
    A_GRN  = 3'd0,
    A_YEL  = 3'd1,
    RED_AB = 3'd2,
    B_GRN  = 3'd3,
    B_YEL  = 3'd4,
    RED_BA = 3'd5,
    WALK   = 3'd6
  } phase_t;

  function automatic lamp_t lamp_a(input phase_t s);
    case (s)
      A_GRN:   lamp_a = LAMP_GREEN;
      A_YEL:   lamp_a = LAMP_YELLOW;
      default: lamp_a = LAMP_RED;
    endcase
  endfunction

  function automatic lamp_t lamp_b(input phase_t s);
    case (s)
      B_GRN:   lamp_b = LAMP_GREEN;
      B_YEL:   lamp_b = LAMP_YELLOW;
      default: lamp_b = LAMP_RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_timer.sv
// phase_timer: per-phase cycle counter for the traffic phase scheduler.
// Counts cycles spent in the current phase, saturating at GREEN_MAX_CYC-1,
// and exposes terminal-count flags for each phase length.
// Ports:
//   i_clk        clock, rising edge
//   i_rstn       asynchronous active-low reset
//   i_clr        synchronous clear (asserted on the edge that changes phase)
//   o_min_done   green has lasted at least GREEN_MIN_CYC cycles
//   o_max_hit    green has reached GREEN_MAX_CYC cycles
//   o_yel_done   last yellow cycle
//   o_red_done   last all-red cycle
//   o_walk_done  last walk cycle
module phase_timer #(
  parameter int CNT_W         = 6,
  parameter int GREEN_MIN_CYC = 8,
  parameter int GREEN_MAX_CYC = 32,
  parameter int YELLOW_CYC    = 3,
  parameter int ALLRED_CYC    = 2,
  parameter int WALK_CYC      = 6
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_clr,
  output logic o_min_done,
  output logic o_max_hit,
  output logic o_yel_done,
  output logic o_red_done,
  output logic o_walk_done
);

  localparam logic [CNT_W-1:0] SAT_T  = CNT_W'(GREEN_MAX_CYC - 1);
  localparam logic [CNT_W-1:0] MIN_T  = CNT_W'(GREEN_MIN_CYC - 1);
  localparam logic [CNT_W-1:0] YEL_T  = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] RED_T  = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] WALK_T = CNT_W'(WALK_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Saturation keeps an idle green (no demand) from wrapping the counter.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (cnt != SAT_T) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_min_done  = (cnt >= MIN_T);
  assign o_max_hit   = (cnt == SAT_T);
  assign o_yel_done  = (cnt == YEL_T);
  assign o_red_done  = (cnt == RED_T);
  assign o_walk_done = (cnt == WALK_T);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: phase scheduler for a two-road (A/B) intersection.
// Sequences green / yellow / all-red phases from road demand (TA/TB) with
// minimum and maximum green limits; a parade override parks road B on green.
// Optional feature macro: PED_WALK_EN adds a pedestrian WALK phase entered
// from all-red; without it i_ped_req is ignored and o_walk/o_ped_ack stay 0.
// Ports:
//   i_clk      clock, rising edge
//   i_rstn     asynchronous active-low reset
//   i_TA/i_TB  car present on road A / road B
//   i_P / i_R  parade set / release (set wins when both high)
//   i_ped_req  pedestrian button, level or pulse
//   o_LA/o_LB  lamp drive, 00 green, 01 yellow, 10 red
//   o_walk     pedestrian walk lamp
//   o_ped_ack  one-cycle pulse on entry to WALK
//   o_phase    current state code
module traffic_phase_scheduler
  import traffic_phase_scheduler_pkg::*;
#(
  parameter int GREEN_MIN_CYC = 8,
  parameter int GREEN_MAX_CYC = 32,
  parameter int YELLOW_CYC    = 3,
  parameter int ALLRED_CYC    = 2,
  parameter int WALK_CYC      = 6,
  parameter int CNT_W         = 6
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_TA,
  input  logic       i_TB,
  input  logic       i_P,
  input  logic       i_R,
  input  logic       i_ped_req,
  output logic [1:0] o_LA,
  output logic [1:0] o_LB,
  output logic       o_walk,
  output logic       o_ped_ack,
  output logic [2:0] o_phase
);

  phase_t state;
  phase_t state_nxt;
  logic   parade;
  logic   par_eff;
  logic   ped_pend;
  logic   next_dir;
  logic   min_done;
  logic   max_hit;
  logic   yel_done;
  logic   red_done;
  logic   walk_done;

  phase_timer #(
    .CNT_W        (CNT_W),
    .GREEN_MIN_CYC(GREEN_MIN_CYC),
    .GREEN_MAX_CYC(GREEN_MAX_CYC),
    .YELLOW_CYC   (YELLOW_CYC),
    .ALLRED_CYC   (ALLRED_CYC),
    .WALK_CYC     (WALK_CYC)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_clr      (state_nxt != state),
    .o_min_done (min_done),
    .o_max_hit  (max_hit),
    .o_yel_done (yel_done),
    .o_red_done (red_done),
    .o_walk_done(walk_done)
  );

  // Parade value as it will be after this edge, so P/R act on the edge that
  // samples them rather than one cycle later.
  assign par_eff = i_P | (parade & ~i_R);

`ifdef PED_WALK_EN
  // ped_pend clears on WALK entry; a request seen during WALK re-arms it.
  // next_dir remembers which green is owed once WALK finishes (1 = road B).
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ped_pend <= 1'b0;
      next_dir <= 1'b0;
    end else begin
      if ((state_nxt == WALK) && (state != WALK)) begin
        ped_pend <= 1'b0;
      end else if (i_ped_req) begin
        ped_pend <= 1'b1;
      end
      if ((state == RED_AB) && (state_nxt == WALK)) begin
        next_dir <= 1'b1;
      end else if ((state == RED_BA) && (state_nxt == WALK)) begin
        next_dir <= 1'b0;
      end
    end
  end
`else
  logic ped_req_unused;
  assign ped_req_unused = i_ped_req;
  assign ped_pend       = 1'b0;
  assign next_dir       = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      A_GRN: begin
        if (min_done && (par_eff || ped_pend || (i_TB && (!i_TA || max_hit))))
          state_nxt = A_YEL;
      end
      A_YEL: begin
        if (yel_done) state_nxt = RED_AB;
      end
      RED_AB: begin
        if (red_done) state_nxt = (ped_pend && !par_eff) ? WALK : B_GRN;
      end
      B_GRN: begin
        if (!par_eff && min_done && (ped_pend || (i_TA && (!i_TB || max_hit))))
          state_nxt = B_YEL;
      end
      B_YEL: begin
        if (yel_done) state_nxt = RED_BA;
      end
      RED_BA: begin
        if (red_done) state_nxt = (ped_pend && !par_eff) ? WALK : A_GRN;
      end
      WALK: begin
        if (walk_done) state_nxt = next_dir ? B_GRN : A_GRN;
      end
      default: state_nxt = A_GRN;
    endcase
  end

  // Outputs are decoded from the next state so they switch on the entering edge.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= A_GRN;
      parade    <= 1'b0;
      o_LA      <= LAMP_GREEN;
      o_LB      <= LAMP_RED;
      o_walk    <= 1'b0;
      o_ped_ack <= 1'b0;
      o_phase   <= 3'd0;
    end else begin
      state   <= state_nxt;
      parade  <= par_eff;
      o_LA    <= lamp_a(state_nxt);
      o_LB    <= lamp_b(state_nxt);
      o_phase <= state_nxt;
`ifdef PED_WALK_EN
      o_walk    <= (state_nxt == WALK);
      o_ped_ack <= (state_nxt == WALK) && (state != WALK);
`else
      o_walk    <= 1'b0;
      o_ped_ack <= 1'b0;
`endif
    end
  end

endmodule
